// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: NOOP encoding, instruction-memory FSM states,
// default instruction-memory depth.
package rv32i_pkg;

  localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;

  // addi x0, x0, 0
  localparam logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE      = 2'd0,
    IMEM_WRITE     = 2'd1,
    IMEM_READ_WAIT = 2'd2,
    IMEM_READ_HOLD = 2'd3
  } imem_state_t;

endpackage

// File: rtl/rv32i_imem_sram.sv
// Single-port DEPTH x 32 instruction array: synchronous write, registered read.
// The read register can load the NOOP encoding instead of an array word so
// that error responses flow through the same registered data path.
module rv32i_imem_sram
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_noop,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Array write port; contents are never touched by reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read data, cleared by reset, loaded only on a read strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_noop ? NOOP_INSTRUCTION : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv32i_imem_responder.sv
// Instruction-memory responder: serves one fetch read at a time with a
// configurable latency, holds the response until consumed, accepts loader
// writes with a one-cycle acknowledge, and aborts reads on flush.
// Optional feature macro: RV32I_IMEM_BOUNDS_CHECK_EN (misaligned or
// out-of-range accesses return a NOOP error response / drop the write).
module rv32i_imem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH        = IMEM_DEPTH_DEFAULT,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_rd_en,
  input  logic [31:0] i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_rd_err,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_valid
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

  imem_state_t      r_state;
  imem_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;
  logic             r_bad;
  logic             w_bad_nxt;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic             r_wr_valid;

  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_rd_bad;
  logic             w_wr_bad;
  logic             w_we;
  logic             w_re;
  logic             w_noop;
  logic [AW-1:0]    w_ram_addr;

  assign w_rd_idx = i_rd_addr[AW+1:2];
  assign w_wr_idx = i_wr_addr[AW+1:2];

`ifdef RV32I_IMEM_BOUNDS_CHECK_EN
  // Misaligned or beyond 4*DEPTH bytes.
  assign w_rd_bad = (i_rd_addr[1:0] != 2'd0) || ((i_rd_addr >> (AW + 2)) != 32'd0);
  assign w_wr_bad = (i_wr_addr[1:0] != 2'd0) || ((i_wr_addr >> (AW + 2)) != 32'd0);
`else
  // Addresses wrap modulo DEPTH; byte offset and high bits are ignored.
  assign w_rd_bad = 1'b0;
  assign w_wr_bad = 1'b0;
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_rd_addr[31:AW+2], i_rd_addr[1:0],
                                i_wr_addr[31:AW+2], i_wr_addr[1:0]};
`endif

  // Next-state, counter and array-port control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_bad_nxt   = r_bad;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_noop      = r_bad;
    w_ram_addr  = r_idx;
    case (r_state)
      IMEM_IDLE: begin
        if (i_flush) begin
          w_state_nxt = IMEM_IDLE;
        end else if (i_wr_en) begin
          w_ram_addr  = w_wr_idx;
          w_we        = !w_wr_bad;
          w_state_nxt = IMEM_WRITE;
        end else if (i_rd_en) begin
          w_idx_nxt = w_rd_idx;
          w_bad_nxt = w_rd_bad;
          w_cnt_nxt = LAT_M1;
          if (READ_LATENCY == 1) begin
            w_ram_addr  = w_rd_idx;
            w_noop      = w_rd_bad;
            w_re        = 1'b1;
            w_state_nxt = IMEM_READ_HOLD;
          end else begin
            w_state_nxt = IMEM_READ_WAIT;
          end
        end
      end
      IMEM_WRITE: begin
        w_state_nxt = IMEM_IDLE;
      end
      IMEM_READ_WAIT: begin
        if (i_flush) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IMEM_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_re        = 1'b1;
            w_state_nxt = IMEM_READ_HOLD;
          end
        end
      end
      IMEM_READ_HOLD: begin
        if (i_flush || i_rd_en) begin
          w_state_nxt = IMEM_IDLE;
        end
      end
      default: begin
        w_state_nxt = IMEM_IDLE;
      end
    endcase
  end

  // State, read context and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IMEM_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_bad      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_wr_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_bad      <= w_bad_nxt;
      r_rd_valid <= (w_state_nxt == IMEM_READ_HOLD);
      r_wr_valid <= (w_state_nxt == IMEM_WRITE);
      if (w_re) begin
        r_rd_err <= w_noop;
      end
    end
  end

  rv32i_imem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we & i_rst_n),
    .i_re    (w_re & i_rst_n),
    .i_noop  (w_noop),
    .i_addr  (w_ram_addr),
    .i_wdata (i_wr_data),
    .o_rdata (o_rd_data)
  );

  assign o_rd_valid = r_rd_valid;
  assign o_rd_err   = r_rd_err;
  assign o_wr_valid = r_wr_valid;

endmodule

// File: tb/tb_rv32i_imem_responder.sv
// Self-checking bench for rv32i_imem_responder against an array-based model.
module tb_rv32i_imem_responder;
  import rv32i_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_model [DEPTH];

  rv32i_imem_responder #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (flush),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_rd_err   (rd_err),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_valid (wr_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef RV32I_IMEM_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return addr_bad(a) ? NOOP_INSTRUCTION : mem_model[word_of(a)];
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loader write from IDLE: ack expected one cycle after request, one cycle wide.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    do begin tick(); n++; end while (!wr_valid && n < 16);
    wr_en = 1'b0;
    check_eq("wr_ack_latency", 32'(n), 32'd1);
    if (!addr_bad(a)) mem_model[word_of(a)] = d;
    tick();
    check_eq("wr_ack_pulse", 32'(wr_valid), 32'd0);
  endtask

  // Fetch read from IDLE with a stall of 'stall' cycles before consuming.
  task automatic do_read(input logic [31:0] a, input int stall);
    int n;
    logic [31:0] e;
    e = exp_data(a);
    n = 0;
    rd_en = 1'b1; rd_addr = a;
    do begin tick(); n++; rd_en = 1'b0; end while (!rd_valid && n < 16);
    check_eq("rd_latency", 32'(n), 32'(LAT));
    check_eq("rd_data", rd_data, e);
    check_eq("rd_err", 32'(rd_err), 32'(addr_bad(a)));
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("hold_valid", 32'(rd_valid), 32'd1);
      check_eq("hold_data", rd_data, e);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("consume_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_eq(tag, 32'(rd_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int n;
    rst_n = 1'b0; flush = 1'b0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_rd_err", 32'(rd_err), 32'd0);
    check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < int'(DEPTH); i++) do_write(32'(i) * 32'd4, $urandom());
    do_write(32'h40, 32'hDEADBEEF);

    // Basic read with a 5-cycle stall before consume.
    do_read(32'h40, 5);

    // Write and read requested together: write first, read sees new value.
    d = $urandom();
    wr_en = 1'b1; wr_addr = 32'h80; wr_data = d;
    rd_en = 1'b1; rd_addr = 32'h80;
    n = 0;
    do begin tick(); n++; end while (!wr_valid && n < 16);
    wr_en = 1'b0;
    check_eq("coll_wr_ack_latency", 32'(n), 32'd1);
    check_eq("coll_no_rd_valid", 32'(rd_valid), 32'd0);
    mem_model[word_of(32'h80)] = d;
    n = 0;
    do begin tick(); n++; end while (!rd_valid && n < 16);
    check_eq("coll_rd_latency", 32'(n), 32'(LAT + 1));
    check_eq("coll_rd_data", rd_data, d);
    tick();
    rd_en = 1'b0;
    check_eq("coll_consume", 32'(rd_valid), 32'd0);

    // Flush during READ_WAIT.
    rd_en = 1'b1; rd_addr = 32'h44;
    tick();
    rd_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_wait_valid", 32'(rd_valid), 32'd0);
    check_quiet("flush_wait_quiet", 4);

    // Flush during READ_HOLD.
    rd_en = 1'b1; rd_addr = 32'h44;
    n = 0;
    do begin tick(); n++; rd_en = 1'b0; end while (!rd_valid && n < 16);
    check_eq("flush_hold_pre_latency", 32'(n), 32'(LAT));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_hold_valid", 32'(rd_valid), 32'd0);
    check_quiet("flush_hold_quiet", 3);
    do_read(32'h44, 0);

    // Reset during READ_WAIT: outputs cleared, array kept.
    rd_en = 1'b1; rd_addr = 32'h40;
    tick();
    rd_en = 1'b0; rst_n = 1'b0;
    tick();
    check_eq("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mid_rst_rd_data", rd_data, 32'd0);
    check_eq("mid_rst_rd_err", 32'(rd_err), 32'd0);
    check_eq("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    rst_n = 1'b1;
    check_quiet("post_rst_quiet", 3);
    do_read(32'h40, 1);

    // Boundary addresses: misaligned and one past the end.
    do_read(32'h42, 0);
    do_read(32'(4 * DEPTH), 0);

    // Randomized mix of writes, stalled reads and flushed reads.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(rand_addr(), $urandom());
        1, 2: do_read(rand_addr(), int'($urandom_range(0, 3)));
        default: begin
          rd_en = 1'b1; rd_addr = rand_addr();
          tick();
          rd_en = 1'b0;
          if ($urandom_range(0, 1) == 1) tick();
          flush = 1'b1;
          tick();
          flush = 1'b0;
          check_eq("rand_flush_valid", 32'(rd_valid), 32'd0);
          check_quiet("rand_flush_quiet", 1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
